// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU for the EX stage.
// One shift-add or restoring shift-subtract step per cycle into HI/LO.
module ex_muldiv_unit #(
   parameter int INST_SZ = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic [INST_SZ-1:0] i_operand_a,
   input  logic [INST_SZ-1:0] i_operand_b,
   input  logic               i_flush,
   output logic               o_busy,
   output logic               o_done,
   output logic [INST_SZ-1:0] o_hi,
   output logic [INST_SZ-1:0] o_lo,
   output logic               o_div_by_zero
);

   localparam int N  = INST_SZ;
   localparam int CW = $clog2(INST_SZ + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(INST_SZ);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_FIX,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic [N-1:0]   mag_a_q, mag_a_d;
   logic [N-1:0]   mag_b_q, mag_b_d;
   logic [N-1:0]   raw_a_q, raw_a_d;
   logic           neg_q, neg_d;
   logic           rneg_q, rneg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           dbz_q, dbz_d;

   logic           sgn_op;
   logic [N-1:0]   abs_a;
   logic [N-1:0]   abs_b;
   logic [N:0]     mul_sum;
   logic [N:0]     div_rem;
   logic [N:0]     div_diff;
   logic [N-1:0]   new_rem;
   logic           q_bit;
   logic [N-1:0]   quo;
   logic [N-1:0]   rem;
   logic [2*N-1:0] prod;

   // Next-state, datapath step and result fix-up
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      raw_a_d = raw_a_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;

      sgn_op  = ~i_op[0];
      abs_a   = (sgn_op && i_operand_a[N-1]) ? -i_operand_a
                                             : i_operand_a;
      abs_b   = (sgn_op && i_operand_b[N-1]) ? -i_operand_b
                                             : i_operand_b;

      mul_sum = {1'b0, acc_q[2*N-1:N]}
              + (acc_q[0] ? {1'b0, mag_a_q} : {(N+1){1'b0}});

      div_rem  = acc_q[2*N-1:N-1];
      div_diff = div_rem - {1'b0, mag_b_q};
      q_bit    = ~div_diff[N];
      new_rem  = q_bit ? div_diff[N-1:0] : div_rem[N-1:0];

      quo  = acc_q[N-1:0];
      rem  = acc_q[2*N-1:N];
      prod = neg_q ? -acc_q : acc_q;

      if (i_flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  op_d    = i_op;
                  mag_a_d = abs_a;
                  mag_b_d = abs_b;
                  raw_a_d = i_operand_a;
                  neg_d   = sgn_op & (i_operand_a[N-1] ^ i_operand_b[N-1]);
                  rneg_d  = sgn_op & i_operand_a[N-1];
                  cnt_d   = CNT_INIT;
                  dbz_d   = 1'b0;
                  acc_d   = i_op[1] ? {{N{1'b0}}, abs_a}
                                    : {{N{1'b0}}, abs_b};
                  state_d = S_BUSY;
               end
            end
            S_BUSY: begin
               cnt_d = cnt_q - CNT_LAST;
               if (op_q[1]) begin
                  acc_d = {new_rem, acc_q[N-2:0], q_bit};
               end else begin
                  acc_d = {mul_sum, acc_q[N-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               if (!op_q[1]) begin
                  hi_d = prod[2*N-1:N];
                  lo_d = prod[N-1:0];
               end else if (mag_b_q == '0) begin
                  hi_d  = raw_a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  lo_d = neg_q  ? -quo : quo;
                  hi_d = rneg_q ? -rem : rem;
               end
               state_d = S_DONE;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         raw_a_q <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         raw_a_q <= raw_a_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o_busy        = (state_q == S_BUSY) || (state_q == S_FIX);
   assign o_done        = (state_q == S_DONE);
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;
   assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit.
// Driver pushes reference results; a negedge monitor pops on o_done.
module tb_ex_muldiv_unit;

   localparam int N = 32;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_start = 1'b0;
   logic [1:0]    i_op = 2'd0;
   logic [N-1:0]  i_operand_a = '0;
   logic [N-1:0]  i_operand_b = '0;
   logic          i_flush = 1'b0;
   logic          o_busy;
   logic          o_done;
   logic [N-1:0]  o_hi;
   logic [N-1:0]  o_lo;
   logic          o_div_by_zero;

   ex_muldiv_unit #(.INST_SZ(N)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_op          (i_op),
      .i_operand_a   (i_operand_a),
      .i_operand_b   (i_operand_b),
      .i_flush       (i_flush),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_hi          (o_hi),
      .o_lo          (o_lo),
      .o_div_by_zero (o_div_by_zero)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          run = 0;
   int          last_run = 0;
   logic [31:0] reg_hi = '0;
   logic [31:0] reg_lo = '0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      longint sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      e.hi = '0; e.lo = '0; e.dbz = 1'b0; e.cyc = 0;
      case (op)
         2'd0: begin
            sp = sa * sb;
            e.hi = sp[63:32]; e.lo = sp[31:0];
         end
         2'd1: begin
            up = ua * ub;
            e.hi = up[63:32]; e.lo = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
            end else if (op == 2'd2) begin
               sq = sa / sb; sr = sa % sb;
               e.hi = sr[31:0]; e.lo = sq[31:0];
            end else begin
               uq = ua / ub; ur = ua % ub;
               e.hi = ur[31:0]; e.lo = uq[31:0];
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: busy-run length and scoreboard pop on o_done
   always @(negedge i_clk) begin
      exp_t e;
      if (!i_reset) begin
         run = 0;
      end else begin
         if (o_busy) run++;
         else if (run != 0) begin
            last_run = run;
            run = 0;
         end
         if (o_done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("hi", o_hi, e.hi);
               chk("lo", o_lo, e.lo);
               chk("dbz", {31'b0, o_div_by_zero}, {31'b0, e.dbz});
               chk("latency", cyc - e.cyc, N + 1);
               chk("busy_cycles", last_run, N + 1);
               reg_hi = e.hi;
               reg_lo = e.lo;
            end
         end
      end
   end

   task automatic launch(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      exp_t e;
      @(negedge i_clk);
      i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      e = model(op, a, b);
      e.cyc = cyc;
      sbq.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      chk("drain_pending", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      launch(op, a, b);
      drain();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_busy"}, {31'b0, o_busy}, 32'd0);
      chk({name, "_done"}, {31'b0, o_done}, 32'd0);
      chk({name, "_hi"}, o_hi, 32'd0);
      chk({name, "_lo"}, o_lo, 32'd0);
      chk({name, "_dbz"}, {31'b0, o_div_by_zero}, 32'd0);
   endtask

   initial begin
      int dc;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      #1 i_reset = 1'b0;
      #2 chk_zero("reset");
      repeat (2) @(negedge i_clk);
      i_reset = 1'b1;

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
      run_op(2'd2, 32'd7, 32'hFFFF_FFFE);
      run_op(2'd3, 32'd100, 32'd7);
      run_op(2'd3, 32'd7, 32'd0);
      chk("dbz_sticky", {31'b0, o_div_by_zero}, 32'd1);

      launch(2'd1, 32'd2, 32'd3);
      chk("dbz_clear_at_launch", {31'b0, o_div_by_zero}, 32'd0);
      drain();

      launch(2'd1, $urandom, $urandom);
      repeat (9) @(negedge i_clk);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1 i_flush = 1'b0;
      chk("flush_busy", {31'b0, o_busy}, 32'd0);
      chk("flush_hi", o_hi, reg_hi);
      chk("flush_lo", o_lo, reg_lo);
      void'(sbq.pop_back());
      dc = done_cnt;
      repeat (40) @(negedge i_clk);
      chk("flush_no_done", done_cnt - dc, 0);

      dc = done_cnt;
      launch(2'd1, 32'h0000_1234, 32'h0000_0010);
      repeat (5) @(negedge i_clk);
      i_start = 1'b1; i_op = 2'd3;
      i_operand_a = 32'd99; i_operand_b = 32'd0;
      @(negedge i_clk);
      i_start = 1'b0;
      drain();
      repeat (40) @(negedge i_clk);
      chk("ignored_start_one_done", done_cnt - dc, 1);

      dc = done_cnt;
      @(negedge i_clk);
      i_start = 1'b1; i_flush = 1'b1; i_op = 2'd1;
      i_operand_a = 32'd5; i_operand_b = 32'd5;
      @(posedge i_clk);
      #1 i_start = 1'b0; i_flush = 1'b0;
      chk("flush_start_busy", {31'b0, o_busy}, 32'd0);
      repeat (40) @(negedge i_clk);
      chk("flush_start_no_done", done_cnt - dc, 0);

      launch(2'd2, 32'h7FFF_0000, 32'd3);
      repeat (4) @(negedge i_clk);
      #2 i_reset = 1'b0;
      #1 chk_zero("midop_reset");
      void'(sbq.pop_back());
      reg_hi = '0; reg_lo = '0;
      @(negedge i_clk);
      i_reset = 1'b1;
      run_op(2'd1, 32'd3, 32'd4);

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
         run_op(rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It sits directly downstream of the ID/EX pipeline register and consumes its read-data-1/read-data-2 operands plus a decoded mul/div opcode. It executes MULT, MULTU, DIV and DIVU over multiple cycles, writing the HI/LO register pair. While busy it raises a stall request, which the hazard logic uses to drop the ID/EX register enable and freeze the front end.

## Interface
- INST_SZ, 32, operand/result width; the iteration count equals INST_SZ.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  launch request from the ID/EX outputs; sampled only in IDLE.
- i_op  in  2  opcode: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_operand_a  in  INST_SZ  rs value (multiplicand/dividend).
- i_operand_b  in  INST_SZ  rt value (multiplier/divisor).
- i_flush  in  1  abort the in-flight operation (branch/jump squash).
- o_busy  out  1  stall request; high in BUSY and FIX.
- o_done  out  1  one-cycle pulse in DONE; HI/LO are valid.
- o_hi  out  INST_SZ  HI register (product upper half / remainder).
- o_lo  out  INST_SZ  LO register (product lower half / quotient).
- o_div_by_zero  out  1  sticky until next launch; set when a DIV/DIVU completes with divisor 0.

## Operation
- **FSM states:** IDLE, BUSY, FIX, DONE. The state is registered, and o_busy/o_done decode directly from it.
- **IDLE, launch:** on i_start = 1 the unit
  - latches the op;
  - latches |a| and |b| for signed ops (the raw values for unsigned ops);
  - records the result signs: product/quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB];
  - loads the iteration counter with INST_SZ, clears o_div_by_zero, and moves to BUSY.
- **BUSY:** one iteration per cycle; the counter decrements, and the cycle in which it reaches 1 moves to FIX.
  - Multiply: shift-add on a 2*INST_SZ accumulator.
  - Divide: restoring shift-subtract on the remainder/quotient pair.
- **FIX:** applies two's-complement negation where the recorded signs require it, loads o_hi/o_lo, sets o_div_by_zero if applicable, then moves to DONE.
- **DONE:** o_done = 1 for exactly one cycle, then returns to IDLE. A new i_start is accepted only from IDLE, so the earliest relaunch is the cycle after DONE.
- **Division results:** LO = quotient, HI = remainder. The quotient truncates toward zero, and the remainder takes the sign of the dividend.
- **Divide by zero:** HI = dividend (operand a unmodified), LO = all ones, o_div_by_zero = 1, normal latency.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, and no flag.
- **Outputs outside FIX:** o_hi/o_lo hold their last value; they update only in FIX.
- **i_start while not IDLE:** ignored; no queueing.
- **i_flush:**
  - In any state, the next edge goes to IDLE, o_hi/o_lo/o_div_by_zero are untouched, and no o_done is produced.
  - In the same cycle as i_start in IDLE, the flush wins and nothing launches.
- **Reset (asserted, including mid-operation):**
  - state = IDLE, counter = 0;
  - o_busy = 0, o_done = 0;
  - o_hi = 0, o_lo = 0;
  - o_div_by_zero = 0.

## Timing
- **Edge E0:** i_start is sampled in IDLE.
- **Cycles after E0:**
  - o_busy is high for INST_SZ+1 cycles (INST_SZ in BUSY, 1 in FIX), i.e. 33 cycles at the default.
  - New o_hi/o_lo are visible after edge E0+INST_SZ+1.
  - o_done is high from that edge until E0+INST_SZ+2.
- **Total latency:** launch to o_done is INST_SZ+1 edges. The initiation interval is INST_SZ+3 cycles.
- **Flush timing:** i_flush is sampled on the edge; o_busy drops on the same edge that enters IDLE.
- **Reset timing:** deassertion is not synchronized internally; the first i_start is honoured on the first rising edge after release.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, with o_done exactly 33 cycles after the start edge and o_busy high for 33 cycles.
- **MULT and overflow DIV:**
  - MULT 0xFFFFFFFD (-3) × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- **DIV signs:**
  - -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - 7 / -2 -> LO = 0xFFFFFFFD, HI = 1.
  - DIVU 100 / 7 -> LO = 14, HI = 2.
- **Divide by zero:** DIVU 7 / 0 -> HI = 7, LO = 0xFFFFFFFF, o_div_by_zero = 1. A following MULTU 2 × 3 clears the flag at launch and yields LO = 6.
- **Flush and ignored start:**
  - i_flush on busy cycle 10 of a MULTU -> IDLE next edge, no o_done, HI/LO keep their prior values.
  - i_start pulsed during BUSY -> ignored, with only one o_done produced.
  - i_flush together with i_start in IDLE -> no launch.
- **Reset mid-operation:** i_reset low on cycle 5 of a DIV -> o_busy/o_done/o_hi/o_lo/o_div_by_zero = 0 immediately (asynchronous). After release, MULTU 3 × 4 -> LO = 12 at the full latency.
